oled_power_sequencer: RTL
=========================

// Module: oled_power_sequencer
// PURPOSE
//  Owns the SSD1306 OLED link of the frequency counter: runs the power-up sequence
//  (VDD, reset pulse, init commands, VBAT, display-on) and the power-down sequence.
//  In RUN it passes display-data bytes from the frame renderer onto SPI over a
//  valid/ready handshake. Sits between the counter/renderer logic and the uo_out pads.
// PARAMETERS
//  SCLK_DIV    4           clk_ref_in cycles per SCLK half-period (>=1)
//  T_VDD_CYC   50_000      cycles from vcdn low to reset release (1 ms @50 MHz)
//  T_RST_CYC   500         cycles rstn held high before the first command
//  T_VBAT_CYC  5_000_000   cycles waited after vbatn low, and after vbatn high on power-down
// PORTS
//  clk_ref_in      in   1  single clock
//  reset_in        in   1  asynchronous, active-high reset
//  disp_on_in      in   1  level: 1 = power up / stay on; 0 = power down / stay off
//  pix_valid_in    in   1  data byte available
//  pix_data_in     in   8  GDDRAM data byte
//  pix_ready_out   out  1  byte accepted on a cycle with pix_valid_in & pix_ready_out
//  ready_out       out  1  1 only in RUN
//  busy_out        out  1  1 in every state except OFF and RUN
//  oled_rstn_out   out  1  display RES#
//  oled_vbatn_out  out  1  VBAT enable, active low
//  oled_vcdn_out   out  1  VDD enable, active low
//  oled_csn_out    out  1  SPI CS#
//  oled_dc_out     out  1  0 = command, 1 = data
//  oled_clk_out    out  1  SCLK, idle low
//  oled_mosi_out   out  1  MOSI, MSB first
// BEHAVIOUR
//  Reset (async, any state): state=OFF; rstn=0, vbatn=1, vcdn=1, csn=1, dc=0, clk=0,
//   mosi=0; pix_ready=0, ready=0, busy=0. Any byte in flight is abandoned; no SCLK edge after.
//  FSM: OFF -> (disp_on=1) VDD_WAIT: vcdn=0, rstn=0 for T_VDD_CYC -> RST_WAIT: rstn=1 for
//   T_RST_CYC -> INIT: send INIT_ROM[0..INIT_LEN-1], dc=0 -> VBAT_WAIT: vbatn=0 for
//   T_VBAT_CYC -> DISP_ON: send 0xAF, dc=0 -> RUN.
//  RUN: pix_ready=1 when shifter idle and disp_on=1; accepted byte sent with dc=1;
//   pix_ready=0 from the acceptance cycle until the byte's csn rises.
//  disp_on=0 seen in any state past OFF: finish the byte in flight (never truncated), then
//   PD_CMD: send 0xAE (dc=0) only if the state reached INIT or later -> PD_VBAT: if vbatn
//   is 0, set vbatn=1 and wait T_VBAT_CYC -> vcdn=1, rstn=0 -> OFF. PD_VBAT is skipped
//   when vbatn is already 1.
//  disp_on re-asserted during power-down: ignored until OFF, then a fresh power-up.
//  SPI byte (mode 0): cycle 0 csn=0, dc valid, mosi=bit7, clk=0; then 8 periods of
//   SCLK_DIV cycles low + SCLK_DIV cycles high, mosi updates on each falling edge; one
//   cycle after the last high phase clk=0, and csn=1 on the next. Byte = 16*SCLK_DIV+2 cycles.
//   dc and mosi are stable while csn=0. csn is high for >=1 cycle between bytes.
//  Wait counters: width $clog2(max T)+1; load T-1, state leaves on the cycle count==0.
//  All outputs are registered; no combinational path from inputs to outputs.
// STRUCTURE
//  oled_pkg: state enum, INIT_LEN=19, INIT_ROM = {AE,D5,80,A8,1F,8D,14,A1,C8,DA,02,81,8F,
//   D9,F1,DB,40,20,00}, CMD_DISP_ON=8'hAF, CMD_DISP_OFF=8'hAE.
//  Sub-module oled_spi_tx: byte serializer (start/byte/dc in, busy/done out, pins out);
//   the sequencer holds the FSM, wait counter and ROM index.
// TESTING  (SCLK_DIV=2, T_VDD_CYC=10, T_RST_CYC=5, T_VBAT_CYC=20)
//  Reset held, disp_on=1 -> vcdn=1 vbatn=1 rstn=0 csn=1 clk=0; release -> vcdn=0 next cycle.
//  Full power-up -> 19 init bytes then 0xAF decoded from SPI, dc=0 for all, 34 cycles/byte;
//   vbatn falls after byte 19 and 20 cycles before 0xAF; ready_out=1 after 0xAF.
//  RUN, push 0x3C, 0xA5 with continuous valid -> two dc=1 bytes, MSB first, pix_ready low
//   in flight, csn high >=1 cycle between bytes.
//  disp_on=0 mid data byte -> byte completes, 0xAE with dc=0, vbatn=1, 20 cycles later
//   vcdn=1 and rstn=0, busy_out=0.
//  disp_on=0 during VDD_WAIT -> no SPI traffic, vcdn=1 directly; reset asserted mid-byte
//   -> all pins at reset values the same cycle, no further clk edges.

Source files
------------

// File: rtl/oled_pkg.sv
// Shared FSM/serializer encodings and the SSD1306 command set used by the power sequencer.
package oled_pkg;

  typedef enum logic [3:0] {
    ST_OFF,
    ST_VDD_WAIT,
    ST_RST_WAIT,
    ST_INIT,
    ST_VBAT_WAIT,
    ST_DISP_ON,
    ST_RUN,
    ST_PD_CMD,
    ST_PD_VBAT
  } state_t;

  typedef enum logic [2:0] {
    SPI_IDLE,
    SPI_SETUP,
    SPI_LOW,
    SPI_HIGH,
    SPI_TAIL
  } spi_phase_t;

  localparam int         INIT_LEN     = 19;
  localparam logic [7:0] CMD_DISP_ON  = 8'hAF;
  localparam logic [7:0] CMD_DISP_OFF = 8'hAE;

  // 128x32 panel bring-up: clock, mux, charge pump, remap, COM pins, contrast, precharge, VCOMH.
  function automatic logic [7:0] init_rom(input logic [4:0] idx);
    case (idx)
      5'd0:    return 8'hAE;
      5'd1:    return 8'hD5;
      5'd2:    return 8'h80;
      5'd3:    return 8'hA8;
      5'd4:    return 8'h1F;
      5'd5:    return 8'h8D;
      5'd6:    return 8'h14;
      5'd7:    return 8'hA1;
      5'd8:    return 8'hC8;
      5'd9:    return 8'hDA;
      5'd10:   return 8'h02;
      5'd11:   return 8'h81;
      5'd12:   return 8'h8F;
      5'd13:   return 8'hD9;
      5'd14:   return 8'hF1;
      5'd15:   return 8'hDB;
      5'd16:   return 8'h40;
      5'd17:   return 8'h20;
      5'd18:   return 8'h00;
      default: return 8'hE3;
    endcase
  endfunction

endpackage

// File: rtl/oled_spi_tx.sv
// Mode-0 SPI byte serializer: one setup cycle, eight SCLK periods, one trailing low cycle.
module oled_spi_tx
  import oled_pkg::*;
#(
  parameter int SCLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  input  logic       is_data,
  output logic       busy,
  output logic       done,
  output logic       csn,
  output logic       sck,
  output logic       mosi,
  output logic       dc
);

  localparam int            HC_W    = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(SCLK_DIV - 1);

  spi_phase_t      phase_q;
  logic [HC_W-1:0] hc_q;
  logic [2:0]      bit_q;
  logic [7:0]      shreg_q;

  assign busy = (phase_q != SPI_IDLE);
  // done marks the last csn-low cycle so the caller can line up the next byte with one idle cycle.
  assign done = (phase_q == SPI_TAIL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= SPI_IDLE;
      hc_q    <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      csn     <= 1'b1;
      sck     <= 1'b0;
      mosi    <= 1'b0;
      dc      <= 1'b0;
    end else begin
      unique case (phase_q)
        SPI_IDLE: begin
          if (start) begin
            phase_q <= SPI_SETUP;
            hc_q    <= '0;
            bit_q   <= '0;
            shreg_q <= data;
            csn     <= 1'b0;
            dc      <= is_data;
            mosi    <= data[7];
          end
        end
        SPI_SETUP: begin
          phase_q <= SPI_LOW;
          hc_q    <= '0;
        end
        SPI_LOW: begin
          if (hc_q == HC_LAST) begin
            phase_q <= SPI_HIGH;
            hc_q    <= '0;
            sck     <= 1'b1;
          end else begin
            hc_q <= hc_q + HC_W'(1);
          end
        end
        SPI_HIGH: begin
          if (hc_q == HC_LAST) begin
            hc_q <= '0;
            sck  <= 1'b0;
            if (bit_q == 3'd7) begin
              phase_q <= SPI_TAIL;
            end else begin
              phase_q <= SPI_LOW;
              bit_q   <= bit_q + 3'd1;
              mosi    <= shreg_q[6];
              shreg_q <= {shreg_q[6:0], 1'b0};
            end
          end else begin
            hc_q <= hc_q + HC_W'(1);
          end
        end
        SPI_TAIL: begin
          phase_q <= SPI_IDLE;
          csn     <= 1'b1;
        end
        default: phase_q <= SPI_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/oled_power_sequencer.sv
// SSD1306 power-up/power-down sequencer with a RUN-mode pixel byte pass-through onto SPI.
module oled_power_sequencer
  import oled_pkg::*;
#(
  parameter int SCLK_DIV   = 4,
  parameter int T_VDD_CYC  = 50_000,
  parameter int T_RST_CYC  = 500,
  parameter int T_VBAT_CYC = 5_000_000
) (
  input  logic       clk_ref_in,
  input  logic       reset_in,
  input  logic       disp_on_in,
  input  logic       pix_valid_in,
  input  logic [7:0] pix_data_in,
  output logic       pix_ready_out,
  output logic       ready_out,
  output logic       busy_out,
  output logic       oled_rstn_out,
  output logic       oled_vbatn_out,
  output logic       oled_vcdn_out,
  output logic       oled_csn_out,
  output logic       oled_dc_out,
  output logic       oled_clk_out,
  output logic       oled_mosi_out
);

  localparam int T_MAX0 = (T_VDD_CYC > T_RST_CYC) ? T_VDD_CYC : T_RST_CYC;
  localparam int T_MAX  = (T_MAX0 > T_VBAT_CYC) ? T_MAX0 : T_VBAT_CYC;
  localparam int CNT_W  = $clog2(T_MAX) + 1;

  localparam logic [CNT_W-1:0] VDD_LOAD  = CNT_W'(T_VDD_CYC - 1);
  localparam logic [CNT_W-1:0] RST_LOAD  = CNT_W'(T_RST_CYC - 1);
  localparam logic [CNT_W-1:0] VBAT_LOAD = CNT_W'(T_VBAT_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       idx_q, idx_d;
  logic             vcdn_q, vcdn_d;
  logic             vbatn_q, vbatn_d;
  logic             rstn_q, rstn_d;
  logic             pix_ready_q, pix_ready_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;

  logic             spi_start;
  logic [7:0]       spi_data;
  logic             spi_is_data;
  logic             spi_busy;
  logic             spi_done;

  always_ff @(posedge clk_ref_in or posedge reset_in) begin
    if (reset_in) begin
      state_q     <= ST_OFF;
      cnt_q       <= '0;
      idx_q       <= '0;
      vcdn_q      <= 1'b1;
      vbatn_q     <= 1'b1;
      rstn_q      <= 1'b0;
      pix_ready_q <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      vcdn_q      <= vcdn_d;
      vbatn_q     <= vbatn_d;
      rstn_q      <= rstn_d;
      pix_ready_q <= pix_ready_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  // idx_q counts ROM bytes in INIT and doubles as a "command issued" flag in DISP_ON / PD_CMD.
  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
    idx_d       = idx_q;
    vcdn_d      = vcdn_q;
    vbatn_d     = vbatn_q;
    rstn_d      = rstn_q;
    spi_start   = 1'b0;
    spi_data    = 8'h00;
    spi_is_data = 1'b0;
    unique case (state_q)
      ST_OFF: begin
        if (disp_on_in) begin
          state_d = ST_VDD_WAIT;
          cnt_d   = VDD_LOAD;
          vcdn_d  = 1'b0;
          rstn_d  = 1'b0;
        end
      end
      ST_VDD_WAIT: begin
        if (!disp_on_in) begin
          state_d = ST_OFF;
          vcdn_d  = 1'b1;
          rstn_d  = 1'b0;
        end else if (cnt_q == '0) begin
          state_d = ST_RST_WAIT;
          cnt_d   = RST_LOAD;
          rstn_d  = 1'b1;
        end
      end
      ST_RST_WAIT: begin
        if (!disp_on_in) begin
          state_d = ST_OFF;
          vcdn_d  = 1'b1;
          rstn_d  = 1'b0;
        end else if (cnt_q == '0) begin
          state_d = ST_INIT;
          idx_d   = '0;
        end
      end
      ST_INIT: begin
        if (!disp_on_in) begin
          state_d = ST_PD_CMD;
          idx_d   = '0;
        end else if (!spi_busy) begin
          if (idx_q == 5'(INIT_LEN)) begin
            state_d = ST_VBAT_WAIT;
            cnt_d   = VBAT_LOAD;
            vbatn_d = 1'b0;
          end else begin
            spi_start = 1'b1;
            spi_data  = init_rom(idx_q);
            idx_d     = idx_q + 5'd1;
          end
        end
      end
      ST_VBAT_WAIT: begin
        if (!disp_on_in) begin
          state_d = ST_PD_CMD;
          idx_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ST_DISP_ON;
          idx_d   = '0;
        end
      end
      ST_DISP_ON: begin
        if (!disp_on_in) begin
          state_d = ST_PD_CMD;
          idx_d   = '0;
        end else if (!spi_busy) begin
          if (idx_q != '0) begin
            state_d = ST_RUN;
          end else begin
            spi_start = 1'b1;
            spi_data  = CMD_DISP_ON;
            idx_d     = 5'd1;
          end
        end
      end
      ST_RUN: begin
        // A byte offered while pix_ready was high is always taken, even as power-down begins.
        if (pix_valid_in && pix_ready_q) begin
          spi_start   = 1'b1;
          spi_data    = pix_data_in;
          spi_is_data = 1'b1;
        end
        if (!disp_on_in) begin
          state_d = ST_PD_CMD;
          idx_d   = '0;
        end
      end
      ST_PD_CMD: begin
        if (!spi_busy) begin
          if (idx_q == '0) begin
            spi_start = 1'b1;
            spi_data  = CMD_DISP_OFF;
            idx_d     = 5'd1;
          end else if (!vbatn_q) begin
            state_d = ST_PD_VBAT;
            cnt_d   = VBAT_LOAD;
            vbatn_d = 1'b1;
          end else begin
            state_d = ST_OFF;
            vcdn_d  = 1'b1;
            rstn_d  = 1'b0;
          end
        end
      end
      ST_PD_VBAT: begin
        if (cnt_q == '0) begin
          state_d = ST_OFF;
          vcdn_d  = 1'b1;
          rstn_d  = 1'b0;
        end
      end
      default: state_d = ST_OFF;
    endcase

    ready_d     = (state_d == ST_RUN);
    busy_d      = !((state_d == ST_OFF) || (state_d == ST_RUN));
    pix_ready_d = (state_d == ST_RUN) && disp_on_in && !spi_start && (!spi_busy || spi_done);
  end

  oled_spi_tx #(
    .SCLK_DIV (SCLK_DIV)
  ) u_spi_tx (
    .clk     (clk_ref_in),
    .rst     (reset_in),
    .start   (spi_start),
    .data    (spi_data),
    .is_data (spi_is_data),
    .busy    (spi_busy),
    .done    (spi_done),
    .csn     (oled_csn_out),
    .sck     (oled_clk_out),
    .mosi    (oled_mosi_out),
    .dc      (oled_dc_out)
  );

  assign pix_ready_out  = pix_ready_q;
  assign ready_out      = ready_q;
  assign busy_out       = busy_q;
  assign oled_rstn_out  = rstn_q;
  assign oled_vbatn_out = vbatn_q;
  assign oled_vcdn_out  = vcdn_q;

endmodule
